// File: rtl/pipe_stage_buf.sv
// Pipeline-stage buffer: DEPTH-entry circular queue with stage valid/allow_in/ready handshake and flush.
// Optional performance counters are enabled by defining PIPE_BUF_PERF_EN.
module pipe_stage_buf #(
    parameter int                DATA_W    = 64,
    parameter int                DEPTH     = 1,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       prev_valid,
    input  logic [DATA_W-1:0]          i_data,
    output logic                       allow_in,
    output logic                       o_valid,
    output logic [DATA_W-1:0]          o_data,
    input  logic                       next_ready,
    input  logic                       flush,
    output logic [$clog2(DEPTH+1)-1:0] o_count
`ifdef PIPE_BUF_PERF_EN
    ,
    output logic [31:0]                perf_stall_cnt,
    output logic [$clog2(DEPTH+1)-1:0] perf_occ_max
`endif
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [CNT_W-1:0]  r_count;

    logic              w_full;
    logic              w_push;
    logic              w_pop;
    logic [CNT_W-1:0]  w_count_nxt;
    logic [DATA_W-1:0] w_rd_data;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Handshake: an entry moves upstream->here when prev_valid && allow_in, and
    // here->downstream when o_valid && next_ready; flush suppresses both moves.
    assign w_full   = (r_count == CNT_W'(DEPTH));
    assign allow_in = !w_full || next_ready;
    assign o_valid  = (r_count != '0);
    assign w_pop    = o_valid && next_ready && !flush;
    assign w_push   = prev_valid && allow_in && !flush;
    assign o_data   = w_rd_data;
    assign o_count  = r_count;

    always_comb begin
        w_rd_data = r_mem[0];
        for (int i = 1; i < DEPTH; i++) begin
            if (r_rd_ptr == PTR_W'(i)) begin
                w_rd_data = r_mem[i];
            end
        end
    end

    always_comb begin
        w_count_nxt = r_count;
        if (flush) begin
            w_count_nxt = '0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   w_count_nxt = r_count + CNT_W'(1);
                2'b01:   w_count_nxt = r_count - CNT_W'(1);
                default: w_count_nxt = r_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= RESET_VAL;
            end
        end else begin
            r_count <= w_count_nxt;
            if (flush) begin
                // Storage is left as-is; only the queue bookkeeping is cleared.
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
            end else begin
                if (w_pop) begin
                    r_rd_ptr <= ptr_inc(r_rd_ptr);
                end
                if (w_push) begin
                    r_wr_ptr <= ptr_inc(r_wr_ptr);
                end
            end
            for (int i = 0; i < DEPTH; i++) begin
                if (w_push && (r_wr_ptr == PTR_W'(i))) begin
                    r_mem[i] <= i_data;
                end
            end
        end
    end

`ifdef PIPE_BUF_PERF_EN
    logic [31:0]      r_stall_cnt;
    logic [CNT_W-1:0] r_occ_max;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_occ_max   <= '0;
        end else begin
            if (prev_valid && !allow_in && !flush && (r_stall_cnt != 32'hFFFF_FFFF)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (w_count_nxt > r_occ_max) begin
                r_occ_max <= w_count_nxt;
            end
        end
    end

    assign perf_stall_cnt = r_stall_cnt;
    assign perf_occ_max   = r_occ_max;
`else
    // Counters compiled out: the queue logic above is the whole stage.
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: four instances (DEPTH 1..4) share one stimulus stream
// and are checked every cycle against per-instance queue models plus literal expectations.
module tb_pipe_stage_buf;

  localparam int W = 16;
  localparam logic [W-1:0] RV = 16'hA5A5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic prev_valid = 1'b0;
  logic [W-1:0] i_data = '0;
  logic next_ready = 1'b0;
  logic flush = 1'b0;

  logic [3:0] allow_w;
  logic [3:0] valid_w;
  logic [W-1:0] data_w [4];
  logic [2:0] cnt_w [4];
`ifdef PIPE_BUF_PERF_EN
  logic [31:0] stall_w [4];
  logic [2:0] occ_w [4];
`endif

  int total = 0;
  int bad = 0;

  // clock / reset block
  always #5 clk = ~clk;

  for (genvar k = 0; k < 4; k++) begin : g_dut
    localparam int CW = $clog2(k + 2);
    logic [CW-1:0] cnt;
`ifdef PIPE_BUF_PERF_EN
    logic [CW-1:0] occ;
`endif
    pipe_stage_buf #(.DATA_W(W), .DEPTH(k + 1), .RESET_VAL(RV)) u_dut (
      .clk(clk),
      .rst(rst),
      .prev_valid(prev_valid),
      .i_data(i_data),
      .allow_in(allow_w[k]),
      .o_valid(valid_w[k]),
      .o_data(data_w[k]),
      .next_ready(next_ready),
      .flush(flush),
      .o_count(cnt)
`ifdef PIPE_BUF_PERF_EN
      ,
      .perf_stall_cnt(stall_w[k]),
      .perf_occ_max(occ)
`endif
    );
    assign cnt_w[k] = 3'(cnt);
`ifdef PIPE_BUF_PERF_EN
    assign occ_w[k] = 3'(occ);
`endif
  end

  // behavioural model: one FIFO queue per instance
  logic [W-1:0] exp_q [4][$];
  bit fresh [4];

  always @(posedge clk or posedge rst) begin
    for (int k = 0; k < 4; k++) begin
      if (rst) begin
        exp_q[k].delete();
        fresh[k] = 1'b1;
      end else begin
        bit acc, take, give;
        acc  = (exp_q[k].size() < k + 1) || next_ready;
        give = (exp_q[k].size() != 0) && next_ready && !flush;
        take = prev_valid && acc && !flush;
        if (flush) begin
          exp_q[k].delete();
        end else begin
          if (give) void'(exp_q[k].pop_front());
          if (take) begin
            exp_q[k].push_back(i_data);
            fresh[k] = 1'b0;
          end
        end
      end
    end
  end

  task automatic check(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s inst%0d (DEPTH=%0d) got=%h expected=%h at %0t", nm, k, k + 1, act, exp, $time);
    end
  endtask

  // scoreboard compare process, away from the active edge
  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      int sz;
      sz = exp_q[k].size();
      check("model_valid", k, 32'(valid_w[k]), 32'(sz != 0));
      check("model_count", k, 32'(cnt_w[k]), 32'(sz));
      check("model_allow", k, 32'(allow_w[k]), 32'((sz < k + 1) || next_ready));
      if (sz != 0) check("model_data", k, 32'(data_w[k]), 32'(exp_q[k][0]));
      else if (fresh[k]) check("model_reset_data", k, 32'(data_w[k]), 32'(RV));
    end
  end

  // driver tasks
  task automatic drive(input logic pv, input logic [W-1:0] d, input logic nr, input logic fl);
    prev_valid = pv;
    i_data = d;
    next_ready = nr;
    flush = fl;
    #2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input string nm, input int k, input logic v, input logic [2:0] c,
                     input logic a, input logic chk_d, input logic [W-1:0] d);
    check({nm, "_valid"}, k, 32'(valid_w[k]), 32'(v));
    check({nm, "_count"}, k, 32'(cnt_w[k]), 32'(c));
    check({nm, "_allow"}, k, 32'(allow_w[k]), 32'(a));
    if (chk_d) check({nm, "_data"}, k, 32'(data_w[k]), 32'(d));
  endtask

  initial begin
    #1 rst = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) lit("reset", k, 1'b0, 3'd0, 1'b1, 1'b1, RV);
    tick();
    tick();
    rst = 1'b0;

    // DEPTH=1 streaming 1,2,3
    drive(1'b1, 16'd1, 1'b1, 1'b0);
    lit("stream0", 0, 1'b0, 3'd0, 1'b1, 1'b1, RV);
    tick();
    drive(1'b1, 16'd2, 1'b1, 1'b0);
    lit("stream1", 0, 1'b1, 3'd1, 1'b1, 1'b1, 16'd1);
    tick();
    drive(1'b1, 16'd3, 1'b1, 1'b0);
    lit("stream2", 0, 1'b1, 3'd1, 1'b1, 1'b1, 16'd2);
    tick();
    drive(1'b0, 16'd0, 1'b1, 1'b0);
    lit("stream3", 0, 1'b1, 3'd1, 1'b1, 1'b1, 16'd3);
    tick();
    drive(1'b0, 16'd0, 1'b0, 1'b0);
    lit("stream_end", 0, 1'b0, 3'd0, 1'b1, 1'b0, '0);
    tick();

    // DEPTH=3 backpressure and wrap
    drive(1'b0, 16'd0, 1'b0, 1'b1);
    tick();
    drive(1'b1, 16'h00A1, 1'b0, 1'b0); tick();
    drive(1'b1, 16'h00B2, 1'b0, 1'b0); tick();
    drive(1'b1, 16'h00C3, 1'b0, 1'b0); tick();
    drive(1'b1, 16'h00D4, 1'b0, 1'b0);
    lit("bp_full", 2, 1'b1, 3'd3, 1'b0, 1'b1, 16'h00A1);
    tick();
    drive(1'b1, 16'h00D4, 1'b0, 1'b0);
    lit("bp_hold", 2, 1'b1, 3'd3, 1'b0, 1'b1, 16'h00A1);
    tick();
    drive(1'b1, 16'h00D4, 1'b1, 1'b0);
    lit("bp_outA", 2, 1'b1, 3'd3, 1'b1, 1'b1, 16'h00A1);
    tick();
    drive(1'b0, 16'd0, 1'b1, 1'b0);
    lit("bp_outB", 2, 1'b1, 3'd3, 1'b1, 1'b1, 16'h00B2);
    tick();
    drive(1'b0, 16'd0, 1'b1, 1'b0);
    lit("bp_outC", 2, 1'b1, 3'd2, 1'b1, 1'b1, 16'h00C3);
    tick();
    drive(1'b0, 16'd0, 1'b1, 1'b0);
    lit("bp_outD", 2, 1'b1, 3'd1, 1'b1, 1'b1, 16'h00D4);
    tick();
    drive(1'b0, 16'd0, 1'b0, 1'b0);
    lit("bp_empty", 2, 1'b0, 3'd0, 1'b1, 1'b0, '0);
    tick();

    // DEPTH=2 full with simultaneous push/pop
    drive(1'b0, 16'd0, 1'b0, 1'b1); tick();
    drive(1'b1, 16'h0A0A, 1'b0, 1'b0); tick();
    drive(1'b1, 16'h0B0B, 1'b0, 1'b0); tick();
    drive(1'b1, 16'h0C0C, 1'b1, 1'b0);
    lit("pp_A", 1, 1'b1, 3'd2, 1'b1, 1'b1, 16'h0A0A);
    tick();
    drive(1'b0, 16'd0, 1'b1, 1'b0);
    lit("pp_B", 1, 1'b1, 3'd2, 1'b1, 1'b1, 16'h0B0B);
    tick();
    drive(1'b0, 16'd0, 1'b1, 1'b0);
    lit("pp_C", 1, 1'b1, 3'd1, 1'b1, 1'b1, 16'h0C0C);
    tick();
    drive(1'b0, 16'd0, 1'b0, 1'b0); tick();

    // DEPTH=4 flush with push and pop offered
    drive(1'b0, 16'd0, 1'b0, 1'b1); tick();
    drive(1'b1, 16'h1E1E, 1'b0, 1'b0); tick();
    drive(1'b1, 16'h1F1F, 1'b0, 1'b0); tick();
    drive(1'b1, 16'h1010, 1'b0, 1'b0); tick();
    drive(1'b1, 16'h1111, 1'b1, 1'b1);
    lit("fl_before", 3, 1'b1, 3'd3, 1'b1, 1'b1, 16'h1E1E);
    tick();
    drive(1'b0, 16'd0, 1'b0, 1'b0);
    lit("fl_after", 3, 1'b0, 3'd0, 1'b1, 1'b0, '0);
    tick();
    drive(1'b1, 16'h1212, 1'b0, 1'b0); tick();
    drive(1'b0, 16'd0, 1'b0, 1'b0);
    lit("fl_next", 3, 1'b1, 3'd1, 1'b1, 1'b1, 16'h1212);
    tick();

    // reset in the middle of traffic
    drive(1'b1, 16'h2121, 1'b0, 1'b0); tick();
    drive(1'b1, 16'h2222, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) lit("midrst", k, 1'b0, 3'd0, 1'b1, 1'b1, RV);
    tick();
    tick();
    rst = 1'b0;

    // mixed traffic checked by the model
    for (int i = 0; i < 120; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 16'($urandom_range(0, 65535)),
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0));
      tick();
    end

`ifdef PIPE_BUF_PERF_EN
    drive(1'b0, 16'd0, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 14; i++) begin
      drive(1'b1, 16'(i), 1'b0, 1'b0);
      tick();
    end
    check("perf_stall", 3, stall_w[3], 32'd10);
    check("perf_occ_max", 3, 32'(occ_w[3]), 32'd4);
`endif

    drive(1'b0, 16'd0, 1'b0, 1'b0);
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
